// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BCD_MAX = 9;

    // Bits needed to hold 10**digits - 1.
    function automatic int min_bin_w(input int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        return $clog2(v);
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake bundle for the BCD-to-binary converter.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (output start, bcd_in, input busy, done, bin_out, err);
    modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_bin_seq_digit_check.sv
// Flags a packed BCD vector that contains any nibble above 9.
module bcd_digit_check
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] bcd,
    output logic                bad
);
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] > 4'(BCD_MAX)) bad = 1'b1;
    end
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one multiply-by-10 and add per cycle,
// most significant digit first, with a start/busy/done handshake.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic             MAX10_CLK1_50,
    input  logic             rst,
    bcd_to_bin_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    generate
        if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
            $error("bcd_to_bin_seq: DIGITS must be in 1..6");
        end
        if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
            $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
        end
    endgenerate

    state_t              state, state_n;
    logic [4*DIGITS-1:0] lat;
    logic [BIN_W-1:0]    acc, acc_n, bin_q;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          digit;
    logic                err_q, bad, last;

    bcd_digit_check #(.DIGITS(DIGITS)) u_chk (
        .bcd (bus.bcd_in),
        .bad (bad)
    );

    // Digits are consumed from the latched copy, so bcd_in may change freely mid-conversion.
    always_comb begin
        digit = lat[4*(DIGITS-1-int'(cnt)) +: 4];
        acc_n = (acc << 3) + (acc << 1) + BIN_W'(digit);
        last  = (cnt == CNT_W'(DIGITS - 1));
    end

    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (bus.start) state_n = bad ? ST_DONE : ST_CONV;
            ST_CONV: if (last)      state_n = ST_DONE;
            ST_DONE:                state_n = ST_IDLE;
            default:                state_n = ST_IDLE;
        endcase
    end

    // bin_out/err change only on entry to DONE and hold until the next result.
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            lat   <= '0;
            acc   <= '0;
            cnt   <= '0;
            bin_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    lat <= bus.bcd_in;
                    acc <= '0;
                    cnt <= '0;
                    if (bad) begin
                        err_q <= 1'b1;
                        bin_q <= '0;
                    end
                end
                ST_CONV: begin
                    acc <= acc_n;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        bin_q <= acc_n;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = (state == ST_DONE);
    assign bus.bin_out = bin_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized scoreboard bench for bcd_to_bin_seq with directed handshake corner cases.
module tb_bcd_to_bin_seq;
    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .MAX10_CLK1_50 (clk),
        .rst           (rst),
        .bus           (bus)
    );

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        logic [15:0]      bcd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;
    int   n_push = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Reference: decimal positional value, error if any digit exceeds 9.
    function automatic exp_t model(input logic [15:0] bcd);
        exp_t e;
        int   v;
        int   d;
        v     = 0;
        e.err = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'((bcd >> (4 * i)) & 16'hF);
            if (d > 9) e.err = 1'b1;
            v = v * 10 + d;
        end
        e.bin = e.err ? '0 : BIN_W'(v);
        e.bcd = bcd;
        return e;
    endfunction

    task automatic push_exp(input logic [15:0] bcd);
        exp_q.push_back(model(bcd));
        n_push++;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("bin_out[%h]", mon_e.bcd), int'(bus.bin_out), int'(mon_e.bin));
                chk($sformatf("err[%h]", mon_e.bcd), int'(bus.err), int'(mon_e.err));
                chk("busy_in_done", int'(bus.busy), 1);
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("idle_timeout", 0, 1);
    endtask

    // mode 0: plain; 1: change bcd_in mid-conversion; 2: pulse start in CONV cycles 2 and 3
    task automatic run(input logic [15:0] bcd, input int mode);
        int   k;
        int   lat;
        int   nbusy;
        int   want;
        exp_t e;
        wait_idle();
        e = model(bcd);
        push_exp(bcd);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(negedge clk);
        bus.start = 1'b0;
        k     = 1;
        lat   = 0;
        nbusy = 0;
        while (k <= 20) begin
            if (bus.busy) nbusy++;
            if (bus.done && lat == 0) lat = k;
            if (mode == 1 && k == 1) bus.bcd_in = 16'h5555;
            if (mode == 2) bus.start = (k == 2 || k == 3);
            if (!bus.busy) break;
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        want = e.err ? 1 : DIGITS + 1;
        chk($sformatf("done_latency[%h]", bcd), lat, want);
        chk($sformatf("busy_cycles[%h]", bcd), nbusy, want);
    endtask

    task automatic run_held();
        int t[3];
        int got;
        int k;
        wait_idle();
        for (int i = 0; i < 3; i++) push_exp(16'h0315);
        bus.bcd_in = 16'h0315;
        bus.start  = 1'b1;
        got = 0;
        k   = 0;
        while (got < 3 && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.done) begin
                t[got] = cyc;
                got++;
                if (got == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("held_pulses", got, 3);
        if (got == 3) begin
            chk("held_gap0", t[1] - t[0], DIGITS + 2);
            chk("held_gap1", t[2] - t[1], DIGITS + 2);
        end
    endtask

    task automatic run_reset_mid();
        wait_idle();
        push_exp(16'h1234);
        bus.bcd_in = 16'h1234;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_bin_out", int'(bus.bin_out), 0);
        chk("rst_err", int'(bus.err), 0);
        void'(exp_q.pop_back());
        n_push--;
        @(negedge clk);
        rst = 1'b0;
        run(16'h0007, 0);
    endtask

    initial begin
        logic [15:0] r;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        rst        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_bin_out", int'(bus.bin_out), 0);
        chk("reset_err", int'(bus.err), 0);
        rst = 1'b0;
        @(negedge clk);

        run(16'h0000, 0);
        run(16'h9999, 0);
        run(16'h1023, 1);
        run(16'h12A4, 0);
        run(16'h0042, 0);
        run(16'h0501, 2);
        run(16'h00F0, 0);
        run_held();
        run_reset_mid();

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
            end else begin
                r = 16'($urandom);
            end
            run(r, int'($urandom_range(0, 2)));
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", n_done, n_push);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
